// File: rtl/usb_pkg.sv
// Types and constants shared by the USB bit-level stages (encoder, stuffer, NRZI).
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        STUFF = 2'd2
    } stuff_state_e;

    localparam int STUFF_RUN_DEF = 6;

endpackage

// File: rtl/bit_stuffer_if.sv
// Serial bit stream into the stuffer and stuffed stream out toward NRZI.
interface bit_stuffer_if;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic [4:0] stuff_cnt;

    modport master (
        output in_bit, in_valid, in_last,
        input  in_ready, out_bit, out_valid, out_last, stuff_cnt
    );

    modport slave (
        input  in_bit, in_valid, in_last,
        output in_ready, out_bit, out_valid, out_last, stuff_cnt
    );
endinterface

// File: rtl/bit_stuffer_ones_run_counter.sv
// Counts consecutive accepted 1s; run_hit flags the 1 that completes a run of RUN.
module ones_run_counter #(
    parameter int RUN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic run_hit
);
    localparam int CW = (RUN > 1) ? $clog2(RUN) : 1;
    localparam logic [CW-1:0] LAST = CW'(RUN - 1);

    logic [CW-1:0] cnt;

    assign run_hit = en && bit_in && (cnt == LAST);

    // A completed run wraps to 0 so the bit after the stuffed 0 starts fresh.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (bit_in && !run_hit) ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/bit_stuffer.sv
// Inserts a 0 after every STUFF_RUN consecutive 1s; one-cycle registered latency.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int STUFF_RUN = STUFF_RUN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    bit_stuffer_if.slave  bs
);
    stuff_state_e state;
    logic         pending_last;
    logic         out_bit_q, out_valid_q, out_last_q;
    logic [4:0]   stuff_cnt_q;
    logic         accept, run_hit;

    assign bs.in_ready  = (state != STUFF);
    assign accept       = bs.in_valid && bs.in_ready;
    assign bs.out_bit   = out_bit_q;
    assign bs.out_valid = out_valid_q;
    assign bs.out_last  = out_last_q;
    assign bs.stuff_cnt = stuff_cnt_q;

    ones_run_counter #(.RUN(STUFF_RUN)) u_run (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .clr     (accept && bs.in_last),
        .bit_in  (bs.in_bit),
        .run_hit (run_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending_last <= 1'b0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            stuff_cnt_q  <= '0;
        end else if (state == STUFF) begin
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            out_last_q   <= pending_last;
            stuff_cnt_q  <= (stuff_cnt_q != 5'd31) ? stuff_cnt_q + 5'd1 : stuff_cnt_q;
            state        <= pending_last ? IDLE : PASS;
            pending_last <= 1'b0;
        end else if (accept) begin
            out_bit_q   <= bs.in_bit;
            out_valid_q <= 1'b1;
            if (state == IDLE)
                stuff_cnt_q <= '0;
            // A stuffing bit defers end-of-packet onto the inserted 0.
            if (run_hit) begin
                out_last_q   <= 1'b0;
                pending_last <= bs.in_last;
                state        <= STUFF;
            end else begin
                out_last_q <= bs.in_last;
                state      <= bs.in_last ? IDLE : PASS;
            end
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bit_stuffer.sv
// Directed table of per-cycle vectors plus a saturation run for bit_stuffer.
module tb_bit_stuffer;
    typedef struct {
        logic       rst;
        logic       v;
        logic       b;
        logic       l;
        logic       rdy;
        logic       ov;
        logic       ob;
        logic       ol;
        logic [4:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    bit_stuffer_if bs ();

    bit_stuffer #(.STUFF_RUN(6)) dut (
        .clk (clk),
        .rst (rst),
        .bs  (bs.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, v, b, l, rdy, ov, ob, ol, input logic [4:0] cnt);
        vec_t x;
        x.rst = r; x.v = v; x.b = b; x.l = l;
        x.rdy = rdy; x.ov = ov; x.ob = ob; x.ol = ol; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [4:0] got, input logic [4:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst         = x.rst;
        bs.in_valid = x.v;
        bs.in_bit   = x.b;
        bs.in_last  = x.l;
        #1;
        if (!x.rst) chk("in_ready", idx, {4'd0, bs.in_ready}, {4'd0, x.rdy});
        @(posedge clk);
        #1;
        chk("out_valid", idx, {4'd0, bs.out_valid}, {4'd0, x.ov});
        chk("out_last", idx, {4'd0, bs.out_last}, {4'd0, x.ol});
        chk("stuff_cnt", idx, bs.stuff_cnt, x.cnt);
        if (x.ov) chk("out_bit", idx, {4'd0, bs.out_bit}, {4'd0, x.ob});
        vectors++;
    endtask

    initial begin
        vec_t x;
        bs.in_valid = 1'b0;
        bs.in_bit   = 1'b0;
        bs.in_last  = 1'b0;

        // reset, then idle
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // 1,0,0,0,0,0,0,0 passes untouched
        for (int i = 0; i < 8; i++)
            add(0, 1, (i == 0), (i == 7), 1, 1, (i == 0), (i == 7), 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // seven 1s, last on 7th: held input during stuff cycle
        for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // six 1s, last on 6th: last moves onto the stuffed 0
        for (int i = 0; i < 6; i++) add(0, 1, 1, (i == 5), 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // twelve 1s: stuffs after bit 6 and bit 12
        for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) add(0, 1, 1, (i == 5), 1, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1, 2);
        // back-to-back: three 1s, 2-cycle bubble, three 1s
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 1, 1, 0, 1, 1);
        // single-bit packet right after IDLE re-entry
        add(0, 1, 1, 1, 1, 1, 1, 1, 0);
        // reset in the would-be stuff cycle
        for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // 32 runs of six 1s in one packet: stuff_cnt saturates at 31
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 6; j++) begin
                x.rst = 0; x.v = 1; x.b = 1; x.l = (k == 31 && j == 5);
                x.rdy = 1; x.ov = 1; x.ob = 1; x.ol = 0;
                x.cnt = (k > 31) ? 5'd31 : 5'(k);
                apply(x, 1000 + k * 7 + j);
            end
            x.rst = 0; x.v = 0; x.b = 0; x.l = 0;
            x.rdy = 0; x.ov = 1; x.ob = 0; x.ol = (k == 31);
            x.cnt = (k + 1 > 31) ? 5'd31 : 5'(k + 1);
            apply(x, 1000 + k * 7 + 6);
        end
        x.rst = 0; x.v = 0; x.b = 0; x.l = 0;
        x.rdy = 1; x.ov = 0; x.ob = 0; x.ol = 0; x.cnt = 5'd31;
        apply(x, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
